// File: rtl/vga_term_ctrl.sv
// vga_term_ctrl: text-terminal front end for the VGA character display.
// Byte-stream handshake: a byte transfers on a rising clk edge where
// in_valid && in_ready; in_ready is high only while idle and in_data must stay
// stable while in_valid && !in_ready. Every screen-buffer write is registered
// and appears on wr_* exactly one cycle after the cycle that caused it.
module vga_term_ctrl #(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int COLOR_W = 12,
  parameter int TAB_W   = 8,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int ATTR_W = 2*COLOR_W+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              attr_load,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic              underline,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  top_row,
  output logic              wr_en,
  output logic [ROW_W-1:0]  wr_row,
  output logic [COL_W-1:0]  wr_col,
  output logic [7:0]        wr_char,
  output logic [ATTR_W-1:0] wr_attr,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {ST_IDLE, ST_CLR_LINE, ST_CLR_SCREEN} state_t;

  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS-1);
  localparam logic [ROW_W:0]    ROWS_EXT = (ROW_W+1)'(ROWS);
  // Power-up attribute: no underline, white foreground, black background.
  localparam logic [ATTR_W-1:0] ATTR_RST = {1'b0, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    cur_row_q, cur_row_d, top_row_q, top_row_d;
  logic [COL_W-1:0]    cur_col_q, cur_col_d;
  logic [ROW_W-1:0]    clr_row_q, clr_row_d;
  logic [COL_W-1:0]    clr_col_q, clr_col_d;
  logic [ATTR_W-1:0]   attr_q, attr_d, clr_attr_q, clr_attr_d;
  logic                wr_en_q, wr_en_d;
  logic [ROW_W-1:0]    wr_row_q, wr_row_d;
  logic [COL_W-1:0]    wr_col_q, wr_col_d;
  logic [7:0]          wr_char_q, wr_char_d;
  logic [ATTR_W-1:0]   wr_attr_q, wr_attr_d;

  logic                accept, do_newline;
  logic [ROW_W:0]      row_sum;
  logic [ROW_W-1:0]    phys_row, top_next;
  logic [COL_W-1:0]    tab_col;
  int                  tab_stop;

  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign cur_row   = cur_row_q;
  assign cur_col   = cur_col_q;
  assign top_row   = top_row_q;
  assign wr_en     = wr_en_q;
  assign wr_row    = wr_row_q;
  assign wr_col    = wr_col_q;
  assign wr_char   = wr_char_q;
  assign wr_attr   = wr_attr_q;
  assign dbg_state = state_q;

  // Cursor-to-buffer row mapping, scroll successor and next tab stop.
  always_comb begin
    row_sum  = {1'b0, top_row_q} + {1'b0, cur_row_q};
    phys_row = (row_sum >= ROWS_EXT) ? ROW_W'(row_sum - ROWS_EXT) : ROW_W'(row_sum);
    top_next = (top_row_q == ROW_MAX) ? '0 : top_row_q + ROW_W'(1);
    tab_stop = (int'(cur_col_q) / TAB_W + 1) * TAB_W;
    tab_col  = (tab_stop > COLS-1) ? COL_MAX : COL_W'(tab_stop);
  end

  // Byte decode, cursor/scroll update, clear sequencing and write generation.
  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    top_row_d  = top_row_q;
    clr_row_d  = clr_row_q;
    clr_col_d  = clr_col_q;
    clr_attr_d = clr_attr_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_char_d  = wr_char_q;
    wr_attr_d  = wr_attr_q;
    do_newline = 1'b0;
    // A coincident printable still writes with attr_q; the new value lands next cycle.
    attr_d     = attr_load ? {underline, fg_color, bg_color} : attr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_row_d  = phys_row;
            wr_col_d  = cur_col_q;
            wr_char_d = in_data;
            wr_attr_d = attr_q;
            if (cur_col_q == COL_MAX) begin
              cur_col_d  = '0;
              do_newline = 1'b1;
            end else begin
              cur_col_d = cur_col_q + COL_W'(1);
            end
          end else begin
            case (in_data)
              8'h0D: cur_col_d = '0;
              8'h0A: do_newline = 1'b1;
              8'h08: if (cur_col_q != '0) cur_col_d = cur_col_q - COL_W'(1);
              8'h09: cur_col_d = tab_col;
              8'h0C: begin
                cur_row_d  = '0;
                cur_col_d  = '0;
                top_row_d  = '0;
                clr_row_d  = '0;
                clr_col_d  = '0;
                clr_attr_d = attr_q;
                state_d    = ST_CLR_SCREEN;
              end
              default: ;
            endcase
          end
          if (do_newline) begin
            if (cur_row_q != ROW_MAX) begin
              cur_row_d = cur_row_q + ROW_W'(1);
            end else begin
              // Scroll: the old top row becomes the new bottom line and is blanked.
              top_row_d  = top_next;
              clr_row_d  = top_row_q;
              clr_col_d  = '0;
              clr_attr_d = attr_q;
              state_d    = ST_CLR_LINE;
            end
          end
        end
      end
      ST_CLR_LINE, ST_CLR_SCREEN: begin
        wr_en_d   = 1'b1;
        wr_row_d  = clr_row_q;
        wr_col_d  = clr_col_q;
        wr_char_d = 8'h20;
        wr_attr_d = clr_attr_q;
        if (clr_col_q != COL_MAX) begin
          clr_col_d = clr_col_q + COL_W'(1);
        end else begin
          clr_col_d = '0;
          if (state_q == ST_CLR_LINE || clr_row_q == ROW_MAX) begin
            state_d = ST_IDLE;
          end else begin
            clr_row_d = clr_row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset starts a full-screen clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLR_SCREEN;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      top_row_q  <= '0;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      attr_q     <= ATTR_RST;
      clr_attr_q <= ATTR_RST;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_char_q  <= '0;
      wr_attr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      top_row_q  <= top_row_d;
      clr_row_q  <= clr_row_d;
      clr_col_q  <= clr_col_d;
      attr_q     <= attr_d;
      clr_attr_q <= clr_attr_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_char_q  <= wr_char_d;
      wr_attr_q  <= wr_attr_d;
    end
  end

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl: inputs change and outputs are sampled on
// the falling clock edge, so each send() returns just after the accept edge
// with the resulting write and cursor update visible.
module tb_vga_term_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        attr_load;
  logic [11:0] fg_color;
  logic [11:0] bg_color;
  logic        underline;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic [4:0]  top_row;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [6:0]  wr_col;
  logic [7:0]  wr_char;
  logic [24:0] wr_attr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int low_cycles;

  localparam logic [24:0] ATTR_WHITE = 25'h0FFF000;
  localparam logic [24:0] ATTR_RED   = 25'h0F00000;

  vga_term_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .attr_load(attr_load), .fg_color(fg_color),
    .bg_color(bg_color), .underline(underline), .cur_row(cur_row),
    .cur_col(cur_col), .top_row(top_row), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_char(wr_char), .wr_attr(wr_attr), .dbg_state(dbg_state)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents one byte for exactly one accept edge.
  task automatic send(input logic [7:0] b, input bit with_attr);
    int t = 0;
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready_wait", 32'(t < 5000), 32'd1);
    in_valid  = 1'b1;
    in_data   = b;
    attr_load = with_attr;
    @(negedge clk);
    in_valid  = 1'b0;
    attr_load = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b, 1'b0);
  endtask

  // Follows a clear burst from the current falling edge until in_ready returns,
  // checking the row-major order, blank character and attribute of every write.
  task automatic watch_clear(input string tag, input int n_exp, input int first_row,
                             input logic [24:0] attr_exp, output int low);
    int n = 0, bad = 0, row = first_row, col = 0;
    bit done = 1'b0;
    low = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (wr_en) begin
        if (wr_char !== 8'h20 || wr_attr !== attr_exp ||
            wr_row !== 5'(row) || wr_col !== 7'(col)) bad++;
        n++;
        col++;
        if (col == 80) begin
          col = 0;
          row++;
        end
      end
      if (in_ready) done = 1'b1;
      else low++;
    end
    chk({tag, "_count"}, 32'(n), 32'(n_exp));
    chk({tag, "_bad_writes"}, 32'(bad), 32'd0);
    chk({tag, "_ready_back"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; attr_load = 1'b0;
    fg_color = 12'h000; bg_color = 12'h000; underline = 1'b0;

    // 1: reset values, then the full-screen clear after release.
    repeat (3) @(negedge clk);
    chk("rst_cur_row", 32'(cur_row), 32'd0);
    chk("rst_cur_col", 32'(cur_col), 32'd0);
    chk("rst_top_row", 32'(top_row), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    watch_clear("boot_clear", 2400, 0, ATTR_WHITE, low_cycles);
    chk("boot_in_ready", 32'(in_ready), 32'd1);

    // 2: two printables at the home position.
    send(8'h41, 1'b0);
    chk("A_wr_en", 32'(wr_en), 32'd1);
    chk("A_wr_row", 32'(wr_row), 32'd0);
    chk("A_wr_col", 32'(wr_col), 32'd0);
    chk("A_wr_char", 32'(wr_char), 32'h41);
    chk("A_wr_attr", 32'(wr_attr), 32'(ATTR_WHITE));
    @(negedge clk);
    chk("A_wr_en_one_cycle", 32'(wr_en), 32'd0);
    send(8'h42, 1'b0);
    chk("B_wr_col", 32'(wr_col), 32'd1);
    chk("B_wr_char", 32'(wr_char), 32'h42);
    chk("B_cur_col", 32'(cur_col), 32'd2);

    // 3: printable in the last column wraps to the next row.
    send(8'h0D, 1'b0);
    send_n(8'h0A, 5);
    send_n(8'h09, 10);
    chk("pre_Z_cur_row", 32'(cur_row), 32'd5);
    chk("pre_Z_cur_col", 32'(cur_col), 32'd79);
    send(8'h5A, 1'b0);
    chk("Z_wr_en", 32'(wr_en), 32'd1);
    chk("Z_wr_row", 32'(wr_row), 32'd5);
    chk("Z_wr_col", 32'(wr_col), 32'd79);
    chk("Z_wr_char", 32'(wr_char), 32'h5A);
    chk("Z_cur_row", 32'(cur_row), 32'd6);
    chk("Z_cur_col", 32'(cur_col), 32'd0);
    chk("Z_in_ready", 32'(in_ready), 32'd1);

    // 4: line feed on the bottom row scrolls and blanks the old top row.
    send_n(8'h0A, 23);
    chk("pre_scroll_cur_row", 32'(cur_row), 32'd29);
    send(8'h0A, 1'b0);
    watch_clear("scroll_clear", 80, 0, ATTR_WHITE, low_cycles);
    chk("scroll_ready_low", 32'(low_cycles), 32'd80);
    chk("scroll_top_row", 32'(top_row), 32'd1);
    chk("scroll_cur_row", 32'(cur_row), 32'd29);
    send(8'h71, 1'b0);
    chk("q_wr_row_wrapped", 32'(wr_row), 32'd0);
    chk("q_wr_col", 32'(wr_col), 32'd0);
    chk("q_cur_col", 32'(cur_col), 32'd1);

    // 5: backspace, tab, ignored bytes and form feed.
    send(8'h08, 1'b0);
    chk("bs_cur_col", 32'(cur_col), 32'd0);
    chk("bs_no_write", 32'(wr_en), 32'd0);
    send(8'h08, 1'b0);
    chk("bs_col0_cur_col", 32'(cur_col), 32'd0);
    chk("bs_col0_no_write", 32'(wr_en), 32'd0);
    send_n(8'h09, 2);
    send_n(8'h08, 3);
    chk("pre_tab13_cur_col", 32'(cur_col), 32'd13);
    send(8'h09, 1'b0);
    chk("tab13_cur_col", 32'(cur_col), 32'd16);
    send_n(8'h09, 8);
    send(8'h08, 1'b0);
    chk("pre_tab78_cur_col", 32'(cur_col), 32'd78);
    send(8'h09, 1'b0);
    chk("tab78_cur_col", 32'(cur_col), 32'd79);
    send(8'h7F, 1'b0);
    send(8'h00, 1'b0);
    send(8'h80, 1'b0);
    chk("ignored_cur_col", 32'(cur_col), 32'd79);
    chk("ignored_cur_row", 32'(cur_row), 32'd29);
    chk("ignored_no_write", 32'(wr_en), 32'd0);
    send(8'h0C, 1'b0);
    chk("ff_cur_row", 32'(cur_row), 32'd0);
    chk("ff_cur_col", 32'(cur_col), 32'd0);
    chk("ff_top_row", 32'(top_row), 32'd0);
    watch_clear("ff_clear", 2400, 0, ATTR_WHITE, low_cycles);
    chk("ff_ready_low", 32'(low_cycles), 32'd2400);

    // 6: attribute load coincident with a printable, then reset during a line clear.
    fg_color = 12'hF00; bg_color = 12'h000; underline = 1'b0;
    send(8'h78, 1'b1);
    chk("x_wr_attr_old", 32'(wr_attr), 32'(ATTR_WHITE));
    chk("x_wr_char", 32'(wr_char), 32'h78);
    fg_color = 12'h123; bg_color = 12'h456; underline = 1'b1;
    send(8'h79, 1'b0);
    chk("y_wr_attr_new", 32'(wr_attr), 32'(ATTR_RED));
    chk("y_wr_col", 32'(wr_col), 32'd1);
    send_n(8'h0A, 30);
    repeat (10) @(negedge clk);
    chk("midclr_wr_en", 32'(wr_en), 32'd1);
    chk("midclr_wr_col", 32'(wr_col), 32'd9);
    chk("midclr_wr_attr", 32'(wr_attr), 32'(ATTR_RED));
    chk("midclr_top_row", 32'(top_row), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_top_row", 32'(top_row), 32'd0);
    chk("abort_cur_row", 32'(cur_row), 32'd0);
    rst_n = 1'b1;
    watch_clear("abort_clear", 2400, 0, ATTR_WHITE, low_cycles);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
